// File: rtl/output_interface.sv
// rtl/output_interface.sv - captures a ciphertext block on engine completion and streams it out MSB byte first
module output_interface #(
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     engine_done,
    input  logic [8*BLOCK_BYTES-1:0] cipher_in,
    output logic [7:0]               dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int              W    = 8 * BLOCK_BYTES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             done_rise;
    logic             load;
    logic             xfer;

    assign done_rise = engine_done & ~done_q;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        xfer       = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
        tx_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (done_rise) begin
                    load       = 1'b1;
                    next_state = S_SEND;
                end
            end
            S_SEND: begin
                dout_valid = 1'b1;
                busy       = 1'b1;
                xfer       = dout_ready;
                if (dout_ready && (cnt == LAST)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                tx_done    = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        dout = dout_valid ? shreg[W-1 -: 8] : 8'h00;
    end

    // cnt saturates at LAST so it never exceeds the block size for any legal parameter pair
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= engine_done;
            if (load) begin
                shreg <= cipher_in;
                cnt   <= '0;
            end else if (xfer) begin
                shreg <= shreg << 8;
                if (cnt != LAST) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // A rise while busy drops that block; set takes priority over clear
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            overrun <= 1'b0;
        end else if (done_rise && (state != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
